wb_fifo_mailbox: RTL and testbench

- Wishbone slave that consumes the 16-bit single-master Wishbone transactions issued by the hostbus-to-Wishbone bridge.
- Provides a host-to-fabric TX FIFO and a fabric-to-host RX FIFO, each with a valid/ready stream port.
- Provides status, level and control registers, plus a registered interrupt output.
- Sits directly downstream of the bridge. It is the first addressable peripheral on its Wishbone bus.

---
 rtl/wb_fifo_mailbox_if.sv | 20 ++
 rtl/wb_fifo_mailbox.sv | 160 ++++++++++++++++
 tb/tb_wb_fifo_mailbox.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_fifo_mailbox_if.sv
// Wishbone bus bundle between the hostbus bridge (master) and the mailbox (slave).
interface wb_fifo_mailbox_if;
    logic        wb_cycle;
    logic        wb_strobe;
    logic        wb_write;
    logic [15:0] wb_addr;
    logic [15:0] wb_wrData;
    logic        wb_ack;
    logic [15:0] wb_rdData;

    modport master (
        output wb_cycle, wb_strobe, wb_write, wb_addr, wb_wrData,
        input  wb_ack, wb_rdData
    );

    modport slave (
        input  wb_cycle, wb_strobe, wb_write, wb_addr, wb_wrData,
        output wb_ack, wb_rdData
    );
endinterface

// File: rtl/wb_fifo_mailbox.sv
// Wishbone mailbox: host-to-fabric TX FIFO, fabric-to-host RX FIFO,
// status/level/control registers and a registered RX interrupt.
module wb_fifo_mailbox #(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    wb_fifo_mailbox_if.slave    wb,
    output logic [15:0]         tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [15:0]         rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                irq
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0]   level_t;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    localparam level_t FULL_LEVEL = level_t'(DEPTH);

    logic [15:0] tx_mem [DEPTH];
    logic [15:0] rx_mem [DEPTH];
    ptr_t        tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    level_t      tx_level, rx_level, tx_level_d, rx_level_d;
    logic        ack_q;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rx_irq_en, tx_ovf, rx_und;

    logic        hit, xfer, rd_xfer, wr_xfer;
    logic [2:0]  idx;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        tx_pop, tx_push_req, tx_push, tx_ovf_evt, tx_flush;
    logic        rx_push, rx_pop_req, rx_pop, rx_und_evt, rx_flush;
    logic        ctrl_wr, clear_sticky;

    assign hit     = wb.wb_cycle & wb.wb_strobe & (wb.wb_addr[15:3] == BASE_ADDR[15:3]);
    // A held strobe re-qualifies only after the ack pulse drops, so every ack is one transaction.
    assign xfer    = hit & ~ack_q;
    assign rd_xfer = xfer & ~wb.wb_write;
    assign wr_xfer = xfer & wb.wb_write;
    assign idx     = wb.wb_addr[2:0];

    assign tx_empty = (tx_level == '0);
    assign tx_full  = (tx_level == FULL_LEVEL);
    assign rx_empty = (rx_level == '0);
    assign rx_full  = (rx_level == FULL_LEVEL);

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rd_ptr];
    assign rx_ready = ~rx_full;

    assign ctrl_wr      = wr_xfer & (idx == 3'd4);
    assign tx_flush     = ctrl_wr & wb.wb_wrData[1];
    assign rx_flush     = ctrl_wr & wb.wb_wrData[2];
    assign clear_sticky = ctrl_wr & wb.wb_wrData[3];

    assign tx_pop      = tx_valid & tx_ready;
    assign tx_push_req = wr_xfer & (idx == 3'd0);
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign tx_ovf_evt  = tx_push_req & ~tx_push;

    assign rx_push    = rx_valid & rx_ready;
    assign rx_pop_req = rd_xfer & (idx == 3'd0);
    assign rx_pop     = rx_pop_req & ~rx_empty;
    assign rx_und_evt = rx_pop_req & rx_empty;

    always_comb begin
        tx_level_d = tx_level;
        if (tx_flush)
            tx_level_d = '0;
        else if (tx_push && !tx_pop)
            tx_level_d = tx_level + level_t'(1);
        else if (!tx_push && tx_pop)
            tx_level_d = tx_level - level_t'(1);
    end

    always_comb begin
        rx_level_d = rx_level;
        if (rx_flush)
            rx_level_d = '0;
        else if (rx_push && !rx_pop)
            rx_level_d = rx_level + level_t'(1);
        else if (!rx_push && rx_pop)
            rx_level_d = rx_level - level_t'(1);
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_xfer) begin
            case (idx)
                3'd0:    rd_data_d = rx_empty ? 16'h0000 : rx_mem[rx_rd_ptr];
                3'd1:    rd_data_d = {10'b0, rx_und, tx_ovf, rx_full, rx_empty, tx_full, tx_empty};
                3'd2:    rd_data_d = 16'(tx_level);
                3'd3:    rd_data_d = 16'(rx_level);
                3'd4:    rd_data_d = {15'b0, rx_irq_en};
                default: rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr] <= wb.wb_wrData;
        if (rx_push)
            rx_mem[rx_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q     <= 1'b0;
            rd_data_q <= '0;
            irq       <= 1'b0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_level  <= '0;
            rx_level  <= '0;
            rx_irq_en <= 1'b0;
            tx_ovf    <= 1'b0;
            rx_und    <= 1'b0;
        end else begin
            ack_q     <= xfer;
            rd_data_q <= rd_data_d;
            irq       <= rx_irq_en & ~rx_empty;
            tx_level  <= tx_level_d;
            rx_level  <= rx_level_d;

            if (tx_flush) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
            end else begin
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + ptr_t'(1);
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + ptr_t'(1);
            end

            // Flush wins over a same-cycle stream push, discarding that word.
            if (rx_flush) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
            end else begin
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + ptr_t'(1);
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + ptr_t'(1);
            end

            if (ctrl_wr)
                rx_irq_en <= wb.wb_wrData[0];

            tx_ovf <= clear_sticky ? tx_ovf_evt : (tx_ovf | tx_ovf_evt);
            rx_und <= clear_sticky ? rx_und_evt : (rx_und | rx_und_evt);
        end
    end

    assign wb.wb_ack    = ack_q;
    assign wb.wb_rdData = rd_data_q;
endmodule

// File: tb/tb_wb_fifo_mailbox.sv
// Scoreboard bench for wb_fifo_mailbox: bus tasks queue expected read data,
// a negedge monitor pops and compares on every ack.
module tb_wb_fifo_mailbox;
    localparam logic [15:0] BASE = 16'h0040;

    logic        clk;
    logic        rst;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        irq;

    int unsigned tests;
    int unsigned fails;
    logic [15:0] exp_q[$];

    wb_fifo_mailbox_if bus ();

    wb_fifo_mailbox #(
        .BASE_ADDR  (BASE),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (bus.slave),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack pulse consumes exactly one scoreboard entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.wb_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got ack with data %h expected no ack", bus.wb_rdData);
            end else begin
                check("rdata", {16'h0, bus.wb_rdData}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic xfer(input logic we, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp, input logic with_pop);
        int unsigned n;
        @(posedge clk); #1;
        bus.wb_cycle  = 1'b1;
        bus.wb_strobe = 1'b1;
        bus.wb_write  = we;
        bus.wb_addr   = a;
        bus.wb_wrData = d;
        if (with_pop) tx_ready = 1'b1;
        exp_q.push_back(we ? 16'h0000 : exp);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            tx_ready = 1'b0;
        end while (bus.wb_ack !== 1'b1 && n < 8);
        check("ack_latency", n, 1);
        if (bus.wb_ack !== 1'b1) void'(exp_q.pop_back());
        bus.wb_cycle  = 1'b0;
        bus.wb_strobe = 1'b0;
        bus.wb_write  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] i, input logic [15:0] d);
        xfer(1'b1, BASE + 16'(i), d, 16'h0000, 1'b0);
    endtask

    task automatic rd(input logic [2:0] i, input logic [15:0] exp);
        xfer(1'b0, BASE + 16'(i), 16'h0000, exp, 1'b0);
    endtask

    initial begin
        int unsigned acks;
        tests = 0;
        fails = 0;
        rst = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        bus.wb_cycle  = 1'b1;
        bus.wb_strobe = 1'b1;
        bus.wb_write  = 1'b0;
        bus.wb_addr   = BASE + 16'd1;
        bus.wb_wrData = '0;

        // Reset held with strobe asserted
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, bus.wb_ack}, 0);
        check("rst_tx_valid", {31'b0, tx_valid}, 0);
        check("rst_rx_ready", {31'b0, rx_ready}, 1);
        check("rst_irq", {31'b0, irq}, 0);
        check("rst_rdata", {16'h0, bus.wb_rdData}, 0);
        bus.wb_cycle  = 1'b0;
        bus.wb_strobe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd(3'd1, 16'h0005);

        // Single TX push, then stream pop
        wr(3'd0, 16'hF0F0);
        check("tx_valid_push", {31'b0, tx_valid}, 1);
        check("tx_data_push", {16'h0, tx_data}, 32'hF0F0);
        rd(3'd2, 16'h0001);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        check("tx_valid_pop", {31'b0, tx_valid}, 0);
        rd(3'd2, 16'h0000);

        // Held strobe: four request cycles give two complete pushes
        @(posedge clk); #1;
        bus.wb_cycle  = 1'b1;
        bus.wb_strobe = 1'b1;
        bus.wb_write  = 1'b1;
        bus.wb_addr   = BASE;
        bus.wb_wrData = 16'h3333;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        repeat (4) @(posedge clk);
        #1;
        bus.wb_cycle  = 1'b0;
        bus.wb_strobe = 1'b0;
        bus.wb_write  = 1'b0;
        rd(3'd2, 16'h0002);
        check("tx_data_hold", {16'h0, tx_data}, 32'h3333);
        wr(3'd4, 16'h0002);
        rd(3'd2, 16'h0000);

        // TX overflow: 16 fit, 17th dropped
        for (int i = 0; i < 16; i++) wr(3'd0, 16'h1000 + 16'(i));
        wr(3'd0, 16'hDEAD);
        rd(3'd2, 16'h0010);
        rd(3'd1, 16'h0016);
        check("tx_head_full", {16'h0, tx_data}, 32'h1000);
        wr(3'd4, 16'h0008);
        rd(3'd1, 16'h0006);
        xfer(1'b1, BASE, 16'hDEAD, 16'h0000, 1'b1);
        rd(3'd2, 16'h0010);
        rd(3'd1, 16'h0006);
        tx_ready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            check("tx_drain", {16'h0, tx_data}, (i == 16) ? 32'hDEAD : 32'h1000 + 32'(i));
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        check("tx_drained", {31'b0, tx_valid}, 0);

        // RX stream, irq, host pops, underflow
        wr(3'd4, 16'h0001);
        rd(3'd4, 16'h0001);
        rx_valid = 1'b1;
        rx_data  = 16'hAAAA;
        @(posedge clk); #1;
        rx_data  = 16'h5555;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
        check("irq_set", {31'b0, irq}, 1);
        rd(3'd3, 16'h0002);
        rd(3'd0, 16'hAAAA);
        rd(3'd0, 16'h5555);
        rd(3'd3, 16'h0000);
        @(posedge clk); #1;
        check("irq_clear", {31'b0, irq}, 0);
        rd(3'd0, 16'h0000);
        rd(3'd1, 16'h0025);

        // RX fill past full, then flush and clear sticky
        rx_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            rx_data = 16'h2000 + 16'(i);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        check("rx_ready_full", {31'b0, rx_ready}, 0);
        rd(3'd3, 16'h0010);
        rd(3'd1, 16'h0029);
        check("irq_full", {31'b0, irq}, 1);
        rd(3'd0, 16'h2000);
        rd(3'd3, 16'h000F);
        wr(3'd4, 16'h0004);
        rd(3'd3, 16'h0000);
        check("rx_ready_flush", {31'b0, rx_ready}, 1);
        rd(3'd1, 16'h0025);
        wr(3'd4, 16'h0008);
        rd(3'd1, 16'h0005);

        // Decode miss and unused indices
        @(posedge clk); #1;
        bus.wb_cycle  = 1'b1;
        bus.wb_strobe = 1'b1;
        bus.wb_write  = 1'b1;
        bus.wb_addr   = BASE + 16'd8;
        bus.wb_wrData = 16'h7777;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.wb_ack === 1'b1) acks++;
        end
        bus.wb_cycle  = 1'b0;
        bus.wb_strobe = 1'b0;
        bus.wb_write  = 1'b0;
        check("miss_acks", acks, 0);
        rd(3'd2, 16'h0000);
        rd(3'd6, 16'h0000);
        wr(3'd7, 16'hFFFF);
        wr(3'd1, 16'hFFFF);
        rd(3'd1, 16'h0005);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
